// File: rtl/instr_mem_if.sv
// Fetch and program-load signal bundle between the IF stage / loader and the
// loadable instruction memory.
interface instr_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] pc;
    logic              fetch_en;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              oob;
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              busy;

    modport master (
        output pc, fetch_en, stall, flush, ld_start, ld_valid, ld_data,
        input  instruction, instr_valid, oob, ld_ready, ld_done, busy
    );

    modport slave (
        input  pc, fetch_en, stall, flush, ld_start, ld_valid, ld_data,
        output instruction, instr_valid, oob, ld_ready, ld_done, busy
    );
endinterface

// File: rtl/instr_mem_loadable.sv
// Instruction memory with registered 1-cycle fetch, stall/flush hooks and a
// streaming loader that rewrites the whole image while the core is held off.
module instr_mem_loadable #(
    parameter int                DATA_W = 16,
    parameter int                ADDR_W = 16,
    parameter int                DEPTH  = 16,
    parameter logic [DATA_W-1:0] NOP    = {DATA_W{1'b0}}
) (
    input  logic      clk_i,
    input  logic      rst_i,
    instr_mem_if.slave imem_io
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              oob_q, oob_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              in_range_s;
    logic [IDX_W-1:0]  idx_s;
    logic              wr_en_s;

    assign in_range_s = ({1'b0, imem_io.pc} < DEPTH_EXT);
    assign idx_s      = imem_io.pc[IDX_W-1:0];
    assign wr_en_s    = (state_q == ST_LOAD) && imem_io.ld_valid && !rst_i;

    // Program image storage; deliberately left out of reset so a reset mid-load keeps written words.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[ptr_q] <= imem_io.ld_data;
        end
    end

    // Next-state logic for the RUN/LOAD controller and the fetch output stage.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        instr_d = instr_q;
        valid_d = valid_q;
        oob_d   = oob_q;
        ready_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (imem_io.ld_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = {IDX_W{1'b0}};
                    busy_d  = 1'b1;
                    ready_d = 1'b1;
                    instr_d = NOP;
                    valid_d = 1'b0;
                    oob_d   = 1'b0;
                end else if (imem_io.flush) begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                    oob_d   = 1'b0;
                end else if (imem_io.stall) begin
                    instr_d = instr_q;
                    valid_d = valid_q;
                    oob_d   = oob_q;
                end else if (imem_io.fetch_en) begin
                    if (in_range_s) begin
                        instr_d = mem_q[idx_s];
                        valid_d = 1'b1;
                        oob_d   = 1'b0;
                    end else begin
                        instr_d = NOP;
                        valid_d = 1'b1;
                        oob_d   = 1'b1;
                    end
                end else begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                    oob_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                busy_d  = 1'b1;
                ready_d = 1'b1;
                if (imem_io.ld_valid) begin
                    if (ptr_q == LAST_IDX) begin
                        state_d = ST_RUN;
                        ptr_d   = {IDX_W{1'b0}};
                        busy_d  = 1'b0;
                        ready_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                end else begin
                    ptr_d = ptr_q;
                end
            end
            default: begin
                state_d = ST_RUN;
                ptr_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Controller state and registered outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            ptr_q   <= {IDX_W{1'b0}};
            instr_q <= NOP;
            valid_q <= 1'b0;
            oob_q   <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            oob_q   <= oob_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign imem_io.instruction = instr_q;
    assign imem_io.instr_valid = valid_q;
    assign imem_io.oob         = oob_q;
    assign imem_io.ld_ready    = ready_q;
    assign imem_io.ld_done     = done_q;
    assign imem_io.busy        = busy_q;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed plus randomized bench for instr_mem_loadable, checked against an
// array-based reference model of the fetch and load rules.
module tb_instr_mem_loadable;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    instr_mem_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    instr_mem_loadable #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .NOP(16'h0000)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .imem_io(bus)
    );

    always #5 clk = ~clk;

    // reference model state
    bit          m_loading;
    int          m_wcount;
    logic [15:0] m_img [DEPTH];
    bit          m_known [DEPTH];
    logic [15:0] m_instr;
    bit          m_instr_known;
    logic        m_valid, m_oob, m_ready, m_done, m_busy;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // What the memory must show after the coming edge, given the inputs now applied.
    task automatic model_edge();
        int p;
        p = int'(bus.pc);
        if (rst) begin
            m_loading = 1'b0; m_wcount = 0;
            m_instr = 16'h0000; m_instr_known = 1'b1;
            m_valid = 1'b0; m_oob = 1'b0;
            m_ready = 1'b0; m_done = 1'b0; m_busy = 1'b0;
        end else if (m_loading) begin
            m_done = 1'b0;
            if (bus.ld_valid) begin
                m_img[m_wcount] = bus.ld_data;
                m_known[m_wcount] = 1'b1;
                m_wcount++;
                if (m_wcount == DEPTH) begin
                    m_loading = 1'b0; m_wcount = 0;
                    m_busy = 1'b0; m_ready = 1'b0; m_done = 1'b1;
                end
            end
        end else begin
            m_done = 1'b0; m_busy = 1'b0; m_ready = 1'b0;
            if (bus.ld_start) begin
                m_loading = 1'b1; m_wcount = 0;
                m_busy = 1'b1; m_ready = 1'b1;
                m_instr = 16'h0000; m_instr_known = 1'b1;
                m_valid = 1'b0; m_oob = 1'b0;
            end else if (bus.flush) begin
                m_instr = 16'h0000; m_instr_known = 1'b1;
                m_valid = 1'b0; m_oob = 1'b0;
            end else if (bus.stall) begin
                m_valid = m_valid;
            end else if (bus.fetch_en) begin
                m_valid = 1'b1;
                if (p < DEPTH) begin
                    m_instr = m_img[p]; m_instr_known = m_known[p]; m_oob = 1'b0;
                end else begin
                    m_instr = 16'h0000; m_instr_known = 1'b1; m_oob = 1'b1;
                end
            end else begin
                m_instr = 16'h0000; m_instr_known = 1'b1;
                m_valid = 1'b0; m_oob = 1'b0;
            end
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        if (m_instr_known) chk16({tag, "_instr"}, bus.instruction, m_instr);
        chk1({tag, "_valid"}, bus.instr_valid, m_valid);
        chk1({tag, "_oob"},   bus.oob,         m_oob);
        chk1({tag, "_ready"}, bus.ld_ready,    m_ready);
        chk1({tag, "_done"},  bus.ld_done,     m_done);
        chk1({tag, "_busy"},  bus.busy,        m_busy);
    endtask

    task automatic idle();
        bus.pc = 16'h0000; bus.fetch_en = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          done_cnt;
        int          k;
        logic [15:0] w;
        logic [15:0] last_w;

        for (int i = 0; i < DEPTH; i++) begin
            m_img[i] = 16'h0000;
            m_known[i] = 1'b0;
        end
        idle();

        // reset held for two cycles
        rst = 1'b1;
        tick("reset0");
        tick("reset1");
        chk16("reset_instr", bus.instruction, 16'h0000);
        chk1("reset_busy", bus.busy, 1'b0);
        rst = 1'b0;

        // full load: 444f, 465f, 14c0 then zeros
        bus.ld_start = 1'b1;
        tick("load1_start");
        bus.ld_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w = (i == 0) ? 16'h444f : (i == 1) ? 16'h465f : (i == 2) ? 16'h14c0 : 16'h0000;
            bus.ld_valid = 1'b1;
            bus.ld_data = w;
            tick("load1_word");
        end
        chk1("load1_done_pulse", bus.ld_done, 1'b1);
        idle();

        // fetches with one-cycle latency
        bus.fetch_en = 1'b1;
        bus.pc = 16'd0; tick("fetch0");
        chk16("fetch0_word", bus.instruction, 16'h444f);
        bus.pc = 16'd1; tick("fetch1");
        chk16("fetch1_word", bus.instruction, 16'h465f);
        bus.pc = 16'd2; tick("fetch2");
        chk16("fetch2_word", bus.instruction, 16'h14c0);
        chk1("fetch2_valid", bus.instr_valid, 1'b1);

        // out of range, no aliasing
        bus.pc = 16'h0010; tick("oob16");
        chk1("oob16_flag", bus.oob, 1'b1);
        chk16("oob16_nop", bus.instruction, 16'h0000);
        bus.pc = 16'hFFFF; tick("oobFFFF");
        bus.pc = 16'h0100; tick("oob0100");
        bus.fetch_en = 1'b0; tick("nofetch");

        // stall holds, flush wins over stall
        bus.fetch_en = 1'b1; bus.pc = 16'd1; tick("pre_stall");
        bus.stall = 1'b1; bus.pc = 16'd2;
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            chk16("stall_hold", bus.instruction, 16'h465f);
        end
        bus.flush = 1'b1; tick("stall_flush");
        chk1("flush_valid", bus.instr_valid, 1'b0);
        idle();

        // load with ld_valid on every other cycle, noisy fetch/ld_start inputs
        bus.ld_start = 1'b1; tick("load2_start");
        done_cnt = 0;
        last_w = 16'h0000;
        k = 0;
        while (m_loading && k < 100) begin
            bus.ld_valid = k[0];
            bus.ld_data = 16'($urandom);
            if (k[0]) last_w = bus.ld_data;
            bus.ld_start = 1'($urandom);
            bus.fetch_en = 1'($urandom);
            bus.stall = 1'($urandom);
            bus.flush = 1'($urandom);
            bus.pc = 16'($urandom_range(0, 20));
            tick("load2");
            if (bus.ld_done) done_cnt++;
            k++;
        end
        idle();
        tick("load2_after");
        if (bus.ld_done) done_cnt++;
        chk_int("load2_done_count", done_cnt, 1);
        bus.fetch_en = 1'b1; bus.pc = 16'd15; tick("fetch15");
        chk16("fetch15_last", bus.instruction, last_w);
        idle();

        // reset after five words of a new load; ld_start during LOAD is ignored
        bus.ld_start = 1'b1; tick("load3_start");
        for (int i = 0; i < 5; i++) begin
            bus.ld_start = 1'b1;
            bus.ld_valid = 1'b1;
            bus.ld_data = 16'($urandom);
            tick("load3_word");
        end
        idle();
        rst = 1'b1; tick("load3_rst");
        rst = 1'b0; tick("load3_idle");
        chk1("load3_busy", bus.busy, 1'b0);
        bus.fetch_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.pc = 16'(i);
            tick("load3_fetch");
        end
        idle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.ld_start = ($urandom_range(0, 15) == 0);
            bus.ld_valid = 1'($urandom);
            bus.ld_data = 16'($urandom);
            bus.fetch_en = 1'($urandom);
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.pc = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 19));
            tick("rand");
        end
        rst = 1'b0;
        idle();
        tick("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
